// File: rtl/spi_wb_master.sv
// Wishbone slave to SPI master: each WB access becomes one 112-bit command frame for a remote
// spi_wb_bridge. The remote ack/err/read data come back on the local bus as a single-cycle strobe.
module spi_wb_master #(
  parameter int CLK_DIV       = 4,
  parameter int CS_GAP        = 8,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        cs_n_o,
  output logic        sclk_o,
  output logic        mosi_o,
  input  logic        miso_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);
  localparam logic [6:0]  LAST_BIT = 7'd111;

  // Byte order on the wire; the swap is its own inverse, so it also restores read data.
  function automatic logic [31:0] wire_order(input logic [31:0] w);
    return LITTLE_ENDIAN ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  state_t        state_reg, state_next;
  logic [15:0]   cnt_reg, cnt_next;
  logic [6:0]    bit_reg, bit_next;
  logic [110:0]  tx_reg, tx_next;
  logic [37:0]   rx_reg, rx_next;
  logic          we_reg, we_next;
  logic [3:0]    sel_reg, sel_next;
  logic          abort_reg, abort_next;
  logic          cs_n_reg, cs_n_next;
  logic          sclk_reg, sclk_next;
  logic          mosi_reg, mosi_next;
  logic          ack_reg, ack_next;
  logic          err_reg, err_next;
  logic [31:0]   dat_reg, dat_next;
  logic          miso_meta, miso_sync;
  logic [111:0]  frame;
  logic          resp_ok;
  logic          keep_bit;

  assign frame = {wbs_we_i, 3'b000, wbs_sel_i, wire_order(wbs_adr_i),
                  wire_order(wbs_we_i ? wbs_dat_i : 32'h0), 32'h0, 8'h01};

  // rx holds rdata[37:6], ack[5], err[4], sel echo[3:0]; the two reserved bits are not stored.
  assign resp_ok  = rx_reg[5] & ~rx_reg[4] & (rx_reg[3:0] == sel_reg);
  assign keep_bit = (bit_reg >= 7'd72) && (bit_reg != 7'd106) && (bit_reg != 7'd107);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      we_reg    <= 1'b0;
      sel_reg   <= '0;
      abort_reg <= 1'b0;
      cs_n_reg  <= 1'b1;
      sclk_reg  <= 1'b0;
      mosi_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_reg   <= '0;
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
      we_reg    <= we_next;
      sel_reg   <= sel_next;
      abort_reg <= abort_next;
      cs_n_reg  <= cs_n_next;
      sclk_reg  <= sclk_next;
      mosi_reg  <= mosi_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      dat_reg   <= dat_next;
      miso_meta <= miso_i;
      miso_sync <= miso_meta;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    tx_next    = tx_reg;
    rx_next    = rx_reg;
    we_next    = we_reg;
    sel_next   = sel_reg;
    abort_next = abort_reg;
    cs_n_next  = cs_n_reg;
    sclk_next  = sclk_reg;
    mosi_next  = mosi_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    dat_next   = dat_reg;

    // A dropped cycle never truncates the frame; it only suppresses the final strobe.
    if (state_reg != IDLE && !wbs_cyc_i) abort_next = 1'b1;

    unique case (state_reg)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          we_next    = wbs_we_i;
          sel_next   = wbs_sel_i;
          tx_next    = frame[110:0];
          mosi_next  = frame[111];
          cs_n_next  = 1'b0;
          cnt_next   = '0;
          bit_next   = '0;
          rx_next    = '0;
          abort_next = 1'b0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next   = '0;
          sclk_next  = 1'b1;
          state_next = SHIFT;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (sclk_reg) begin
            sclk_next = 1'b0;
            if (keep_bit) rx_next = {rx_reg[36:0], miso_sync};
            if (bit_reg != LAST_BIT) begin
              mosi_next = tx_reg[110];
              tx_next   = {tx_reg[109:0], 1'b0};
            end
          end else if (bit_reg == LAST_BIT) begin
            state_next = DONE;
            cs_n_next  = 1'b1;
            mosi_next  = 1'b0;
            if (!abort_reg && wbs_cyc_i) begin
              ack_next = resp_ok;
              err_next = !resp_ok;
              if (resp_ok && !we_reg) dat_next = wire_order(rx_reg[37:6]);
            end
          end else begin
            bit_next  = bit_reg + 7'd1;
            sclk_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = GAP;
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) state_next = IDLE;
        else cnt_next = cnt_reg + 16'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wbs_dat_o = dat_reg;
  assign wbs_ack_o = ack_reg;
  assign wbs_err_o = err_reg;
  assign cs_n_o    = cs_n_reg;
  assign sclk_o    = sclk_reg;
  assign mosi_o    = mosi_reg;
  assign busy_o    = (state_reg != IDLE);

endmodule
